id_ex_hazard_pipe: RTL

Parametrised ID→EX pipeline register for the pipelined RISC-V core, with integrated hazard control.
Captures decoded control, operands, immediate, PC and register addresses; bypasses same-cycle WB writes into captured operands.
Detects load-use hazards and stalls for a configurable load latency. Handles EX-branch flush. Generates EX forwarding selects.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/hazard_fwd_unit.sv | 41 ++++
 rtl/id_ex_hazard_pipe.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the ID->EX pipeline register: control bundle layout,
// forwarding-select encoding and stall FSM states.
package pipe_pkg;

   // Default control bundle layout (12 bits, MSB first).
   typedef struct packed {
      logic       reg_write;
      logic       alu_src;
      logic [1:0] write_src;
      logic       branch;
      logic [2:0] alu_op;
      logic       jump;
      logic       ret;
      logic       mem_write;
      logic       spare;
   } ctrl_t;

   localparam int CTRL_BITS = $bits(ctrl_t);

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } stall_state_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use hazard detection and EX-stage operand forwarding
// selects; holds no state.
module hazard_fwd_unit
   import pipe_pkg::*;
#(
   parameter int RA_W = 5
) (
   input  logic            i_ex_valid,
   input  logic            i_ex_is_load,
   input  logic [RA_W-1:0] i_ex_rd,
   input  logic [RA_W-1:0] i_ex_rs1,
   input  logic [RA_W-1:0] i_ex_rs2,
   input  logic            i_id_valid,
   input  logic [RA_W-1:0] i_rs1,
   input  logic [RA_W-1:0] i_rs2,
   input  logic            i_mem_we,
   input  logic [RA_W-1:0] i_mem_rd,
   input  logic            i_wb_we,
   input  logic [RA_W-1:0] i_wb_rd,
   output logic            o_hz,
   output fwd_sel_t        o_fwd_a,
   output fwd_sel_t        o_fwd_b
);

   // MEM result is younger than WB, so it wins; x0 is hardwired and never forwards.
   function automatic fwd_sel_t pick(input logic [RA_W-1:0] r,
                                     input logic mem_we, input logic [RA_W-1:0] mem_rd,
                                     input logic wb_we,  input logic [RA_W-1:0] wb_rd);
      if (r == '0)                  return FWD_REG;
      if (mem_we && (mem_rd == r))  return FWD_MEM;
      if (wb_we && (wb_rd == r))    return FWD_WB;
      return FWD_REG;
   endfunction

   assign o_hz = i_ex_valid && i_ex_is_load && (i_ex_rd != '0) && i_id_valid &&
                 ((i_ex_rd == i_rs1) || (i_ex_rd == i_rs2));

   assign o_fwd_a = pick(i_ex_rs1, i_mem_we, i_mem_rd, i_wb_we, i_wb_rd);
   assign o_fwd_b = pick(i_ex_rs2, i_mem_we, i_mem_rd, i_wb_we, i_wb_rd);

endmodule

// File: rtl/id_ex_hazard_pipe.sv
// ID->EX pipeline register with WB bypass, load-use stall FSM, EX flush and
// forwarding selects. Define RISCV_PERF_CNT_EN to build the stall/flush counters.
module id_ex_hazard_pipe
   import pipe_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int RA_W         = 5,
   parameter int CTRL_W       = CTRL_BITS,
   parameter int LOAD_LATENCY = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic              is_load_i,
   input  logic [RA_W-1:0]   rs1_i,
   input  logic [RA_W-1:0]   rs2_i,
   input  logic [RA_W-1:0]   rd_i,
   input  logic [XLEN-1:0]   rd1_i,
   input  logic [XLEN-1:0]   rd2_i,
   input  logic [XLEN-1:0]   imm_i,
   input  logic [XLEN-1:0]   pc_i,
   input  logic [XLEN-1:0]   pcplus4_i,
   input  logic [2:0]        funct3_i,
   input  logic              mem_we_i,
   input  logic [RA_W-1:0]   mem_rd_i,
   input  logic              wb_we_i,
   input  logic [RA_W-1:0]   wb_rd_i,
   input  logic [XLEN-1:0]   wb_data_i,
   input  logic              flush_i,
   output logic              ex_valid_o,
   output logic              ex_is_load_o,
   output logic [CTRL_W-1:0] ex_ctrl_o,
   output logic [XLEN-1:0]   ex_op1_o,
   output logic [XLEN-1:0]   ex_op2_o,
   output logic [XLEN-1:0]   ex_imm_o,
   output logic [XLEN-1:0]   ex_pc_o,
   output logic [XLEN-1:0]   ex_pcplus4_o,
   output logic [RA_W-1:0]   ex_rs1_o,
   output logic [RA_W-1:0]   ex_rs2_o,
   output logic [RA_W-1:0]   ex_rd_o,
   output logic [2:0]        ex_funct3_o,
   output logic [1:0]        fwd_a_o,
   output logic [1:0]        fwd_b_o,
   output logic              stall_o,
   output logic [31:0]       stall_cnt_o,
   output logic [31:0]       flush_cnt_o
);

   typedef struct packed {
      logic              valid;
      logic              is_load;
      logic [CTRL_W-1:0] ctrl;
      logic [XLEN-1:0]   op1;
      logic [XLEN-1:0]   op2;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   pcplus4;
      logic [RA_W-1:0]   rs1;
      logic [RA_W-1:0]   rs2;
      logic [RA_W-1:0]   rd;
      logic [2:0]        funct3;
   } ex_t;

   localparam logic [1:0] LL_M1 = 2'(LOAD_LATENCY - 1);

   ex_t          r_ex;
   ex_t          w_next;
   stall_state_t r_state;
   logic [1:0]   r_cnt;
   logic         w_hz;
   logic         w_stall;
   logic         w_bubble;
   fwd_sel_t     w_fwd_a;
   fwd_sel_t     w_fwd_b;

   hazard_fwd_unit #(.RA_W(RA_W)) u_hfu (
      .i_ex_valid   (r_ex.valid),
      .i_ex_is_load (r_ex.is_load),
      .i_ex_rd      (r_ex.rd),
      .i_ex_rs1     (r_ex.rs1),
      .i_ex_rs2     (r_ex.rs2),
      .i_id_valid   (id_valid_i),
      .i_rs1        (rs1_i),
      .i_rs2        (rs2_i),
      .i_mem_we     (mem_we_i),
      .i_mem_rd     (mem_rd_i),
      .i_wb_we      (wb_we_i),
      .i_wb_rd      (wb_rd_i),
      .o_hz         (w_hz),
      .o_fwd_a      (w_fwd_a),
      .o_fwd_b      (w_fwd_b)
   );

   // Flush kills both a fresh hazard and an in-progress stall.
   assign w_stall  = !flush_i && ((r_state == ST_STALL) || w_hz);
   assign w_bubble = flush_i || w_stall;

   always_comb begin
      // NOTE: the all-zero default is the bubble and also keeps this block latch-free.
      w_next = '0;
      if (!w_bubble) begin
         w_next.valid   = id_valid_i;
         w_next.is_load = is_load_i;
         w_next.ctrl    = ctrl_i;
         w_next.op1     = (wb_we_i && (wb_rd_i != '0) && (wb_rd_i == rs1_i)) ? wb_data_i : rd1_i;
         w_next.op2     = (wb_we_i && (wb_rd_i != '0) && (wb_rd_i == rs2_i)) ? wb_data_i : rd2_i;
         w_next.imm     = imm_i;
         w_next.pc      = pc_i;
         w_next.pcplus4 = pcplus4_i;
         w_next.rs1     = rs1_i;
         w_next.rs2     = rs2_i;
         w_next.rd      = rd_i;
         w_next.funct3  = funct3_i;
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking so the FSM and EX bundle all see pre-edge values.
      if (rst_i) begin
         r_ex    <= '0;
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_ex <= w_next;
         if (flush_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end else if (r_state == ST_STALL) begin
            r_cnt <= r_cnt - 2'd1;
            if (r_cnt == 2'd1) r_state <= ST_IDLE;
         end else if (w_hz) begin
            r_cnt   <= LL_M1;
            r_state <= (LL_M1 != 2'd0) ? ST_STALL : ST_IDLE;
         end
      end
   end

   assign ex_valid_o   = r_ex.valid;
   assign ex_is_load_o = r_ex.is_load;
   assign ex_ctrl_o    = r_ex.ctrl;
   assign ex_op1_o     = r_ex.op1;
   assign ex_op2_o     = r_ex.op2;
   assign ex_imm_o     = r_ex.imm;
   assign ex_pc_o      = r_ex.pc;
   assign ex_pcplus4_o = r_ex.pcplus4;
   assign ex_rs1_o     = r_ex.rs1;
   assign ex_rs2_o     = r_ex.rs2;
   assign ex_rd_o      = r_ex.rd;
   assign ex_funct3_o  = r_ex.funct3;
   assign fwd_a_o      = w_fwd_a;
   assign fwd_b_o      = w_fwd_b;
   assign stall_o      = w_stall;

`ifdef RISCV_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (flush_i) r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule
